// File: rtl/y_datapath_core_if.sv
// Decode/execute/memory bus of the single-cycle RV32 datapath slice.
// master drives instruction and controls; slave returns operands, ALU and memory results.
interface y_datapath_core_if;
  logic [31:0] ins;
  logic [31:0] wd;
  logic        RegWrite;
  logic        ALUSrc;
  logic [2:0]  op;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [31:0] branch;
  logic [31:0] jTarget;
  logic [31:0] z;
  logic        zero;
  logic [31:0] memOut;

  modport master (
    output ins, wd, RegWrite, ALUSrc, op, MemRead, MemWrite,
    input  rd1, rd2, imm, branch, jTarget, z, zero, memOut
  );

  modport slave (
    input  ins, wd, RegWrite, ALUSrc, op, MemRead, MemWrite,
    output rd1, rd2, imm, branch, jTarget, z, zero, memOut
  );
endinterface

// File: rtl/y_datapath_core.sv
// Decode/execute/memory slice: register file, immediate/offset generation, ALU, word data memory.
// Optional macro Y_DATAPATH_SLT_EN enables signed set-less-than on op 111.
module y_datapath_core #(
  parameter int unsigned DM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  y_datapath_core_if.slave  bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(DM_WORDS);

  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b110;
  localparam logic [2:0] OP_SLT    = 3'b111;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] mem  [DM_WORDS];

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rdst;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] imm_c;
  logic [XLEN-1:0] res;
  logic [AW-1:0]   idx;

  assign rs1  = bus.ins[19:15];
  assign rs2  = bus.ins[24:20];
  assign rdst = bus.ins[11:7];

  // Register file: async clear, x0 never written so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (bus.RegWrite && (rdst != 5'd0)) begin
      regs[rdst] <= bus.wd;
    end
  end

  assign a = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign bus.rd1 = a;
  assign bus.rd2 = (rs2 == 5'd0) ? '0 : regs[rs2];

  // Store format splits the immediate around the rd field
  assign imm_c = (bus.ins[6:0] == OPC_STORE)
               ? {{20{bus.ins[31]}}, bus.ins[31:25], bus.ins[11:7]}
               : {{20{bus.ins[31]}}, bus.ins[31:20]};
  assign bus.imm     = imm_c;
  assign bus.branch  = {{19{bus.ins[31]}}, bus.ins[31], bus.ins[7],
                        bus.ins[30:25], bus.ins[11:8], 1'b0};
  assign bus.jTarget = {{11{bus.ins[31]}}, bus.ins[31], bus.ins[19:12],
                        bus.ins[20], bus.ins[30:21], 1'b0};

  assign b = bus.ALUSrc ? imm_c : bus.rd2;

  always_comb begin
    res = '0;
    case (bus.op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
`ifdef Y_DATAPATH_SLT_EN
      OP_SLT: res = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
`else
      OP_SLT: res = '0;
`endif
      default: res = '0;
    endcase
  end

  assign bus.z    = res;
  assign bus.zero = (res == '0);

  // Word index drops byte offset; upper address bits wrap
  assign idx = res[AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DM_WORDS); i++) mem[i] <= '0;
    end else if (bus.MemWrite) begin
      mem[idx] <= bus.rd2;
    end
  end

  assign bus.memOut = bus.MemRead ? mem[idx] : '0;

endmodule

// File: tb/tb_y_datapath_core.sv
// Scoreboard bench for y_datapath_core: expectations queued with stimulus, drained after settling.
// Honours Y_DATAPATH_SLT_EN for the op 111 expectation.
module tb_y_datapath_core;

  localparam int unsigned DM_WORDS = 256;

  typedef enum logic [2:0] {S_RD1, S_RD2, S_IMM, S_BR, S_JT, S_Z, S_ZERO, S_MEM} sig_e;
  typedef struct {
    sig_e        sig;
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  y_datapath_core_if bus ();

  y_datapath_core #(.DM_WORDS(DM_WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_RD1:   return bus.rd1;
      S_RD2:   return bus.rd2;
      S_IMM:   return bus.imm;
      S_BR:    return bus.branch;
      S_JT:    return bus.jTarget;
      S_Z:     return bus.z;
      S_ZERO:  return {31'b0, bus.zero};
      S_MEM:   return bus.memOut;
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
`ifdef Y_DATAPATH_SLT_EN
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic expect_val(input sig_e s, input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.sig = s;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int r, input logic [31:0] val);
    bus.ins      = (32'(r) << 7) | 32'h0000_0033;
    bus.wd       = val;
    bus.RegWrite = 1'b1;
    tick();
    bus.RegWrite = 1'b0;
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic [31:0] slt_exp;

  initial begin
    bus.ins = '0; bus.wd = '0; bus.RegWrite = 1'b0; bus.ALUSrc = 1'b0;
    bus.op = 3'b010; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;

    // Preload state, then assert reset mid-cycle with no clock edge
    write_reg(1, 32'h55);
    bus.ins = 32'h0010_0033; bus.op = 3'b010; bus.ALUSrc = 1'b0; bus.MemWrite = 1'b1;
    tick();
    bus.MemWrite = 1'b0; bus.MemRead = 1'b1;
    expect_val(S_Z,   "pre_rst_z",   32'h55);
    expect_val(S_MEM, "pre_rst_mem", 32'h55);
    drain();
    rst_n = 1'b0;
    #1;
    expect_val(S_RD2, "rst_rd2", 32'h0);
    expect_val(S_MEM, "rst_mem", 32'h0);
    drain();
    bus.ins = 32'h0020_8033;
    expect_val(S_RD1,  "rst_rd1b", 32'h0);
    expect_val(S_RD2,  "rst_rd2b", 32'h0);
    expect_val(S_Z,    "rst_z",    32'h0);
    expect_val(S_ZERO, "rst_zero", 32'h1);
    expect_val(S_MEM,  "rst_memb", 32'h0);
    drain();
    rst_n = 1'b1;
    bus.MemRead = 1'b0;

    // addi x1,x0,5
    bus.ins = 32'h0050_0093; bus.ALUSrc = 1'b1; bus.op = 3'b010;
    bus.wd = 32'd5; bus.RegWrite = 1'b1;
    expect_val(S_IMM, "addi_imm", 32'd5);
    expect_val(S_Z,   "addi_z",   32'd5);
    drain();
    tick();
    bus.RegWrite = 1'b0;
    bus.ins = 32'h0000_8033;
    expect_val(S_RD1, "x1_after", 32'd5);
    drain();
    write_reg(0, 32'd7);
    bus.ins = 32'h0000_0033;
    expect_val(S_RD1, "x0_stays", 32'd0);
    drain();

    // R-type sub/or/and and unused opcode
    write_reg(2, 32'd5);
    bus.ins = 32'h4020_8033; bus.ALUSrc = 1'b0;
    bus.op = 3'b110;
    expect_val(S_Z, "sub_z", 32'd0); expect_val(S_ZERO, "sub_zero", 32'd1); drain();
    bus.op = 3'b001;
    expect_val(S_Z, "or_z", 32'd5); expect_val(S_ZERO, "or_zero", 32'd0); drain();
    bus.op = 3'b011;
    expect_val(S_Z, "nop_op_z", 32'd0); expect_val(S_ZERO, "nop_op_zero", 32'd1); drain();

    // Store then load
    write_reg(1, 32'd8);
    write_reg(2, 32'hDEAD_BEEF);
    bus.ins = 32'h0020_A223; bus.ALUSrc = 1'b1; bus.op = 3'b010; bus.MemWrite = 1'b1;
    expect_val(S_IMM, "sw_imm", 32'd4);
    expect_val(S_Z,   "sw_z",   32'd12);
    expect_val(S_RD2, "sw_rd2", 32'hDEAD_BEEF);
    drain();
    tick();
    bus.MemWrite = 1'b0;
    bus.ins = 32'h0040_A183; bus.MemRead = 1'b1;
    expect_val(S_IMM, "lw_imm", 32'd4);
    expect_val(S_Z,   "lw_z",   32'd12);
    expect_val(S_MEM, "lw_mem", 32'hDEAD_BEEF);
    drain();
    bus.MemRead = 1'b0;
    expect_val(S_MEM, "lw_noread", 32'h0);
    drain();

    // Wrapped address hits the same word; simultaneous read returns old data
    write_reg(1, 32'd8 + 32'(4 * DM_WORDS));
    write_reg(2, 32'h1234_5678);
    bus.ins = 32'h0020_A223; bus.MemWrite = 1'b1; bus.MemRead = 1'b1;
    expect_val(S_Z,   "wrap_z",   32'd12 + 32'(4 * DM_WORDS));
    expect_val(S_MEM, "rdw_old",  32'hDEAD_BEEF);
    drain();
    tick();
    bus.MemWrite = 1'b0;
    expect_val(S_MEM, "rdw_new", 32'h1234_5678);
    drain();
    write_reg(1, 32'd8);
    bus.ins = 32'h0040_A183;
    expect_val(S_MEM, "wrap_lw", 32'h1234_5678);
    drain();
    bus.MemRead = 1'b0;

    // Branch / jump offsets
    bus.ins = 32'hFE00_0EE3;
    expect_val(S_BR,  "branch_m4", 32'hFFFF_FFFC);
    expect_val(S_IMM, "br_imm",    32'hFFFF_FFE0);
    drain();
    bus.ins = 32'hFF9F_F06F;
    expect_val(S_JT, "jt_m8", 32'hFFFF_FFF8);
    drain();
    bus.ins = 32'h0080_0463;
    expect_val(S_BR, "branch_p8", 32'd8);
    drain();

    // Signed SLT with A=-1, B=imm 1
    write_reg(1, 32'hFFFF_FFFF);
    bus.ins = 32'h0010_8013; bus.ALUSrc = 1'b1; bus.op = 3'b111;
`ifdef Y_DATAPATH_SLT_EN
    slt_exp = 32'd1;
`else
    slt_exp = 32'd0;
`endif
    expect_val(S_Z,    "slt_z",    slt_exp);
    expect_val(S_ZERO, "slt_zero", {31'b0, slt_exp == 32'd0});
    drain();

    // Random operands across every op code
    for (int it = 0; it < 4; it++) begin
      ra = $urandom;
      rb = (it == 0) ? ra : $urandom;
      write_reg(5, ra);
      write_reg(6, rb);
      bus.ins = 32'h0062_8033; bus.ALUSrc = 1'b0;
      for (int o = 0; o < 8; o++) begin
        bus.op = 3'(o);
        expect_val(S_Z,    $sformatf("rand%0d_op%0d_z", it, o), alu_model(3'(o), ra, rb));
        expect_val(S_ZERO, $sformatf("rand%0d_op%0d_zero", it, o),
                   {31'b0, alu_model(3'(o), ra, rb) == 32'd0});
        drain();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
